// File: rtl/npc_mem_arbiter.sv
// npc_mem_arbiter: shares the single physical-memory port between the IFU
// (read-only fetch) and the LSU (load/store). Only one transaction is in
// flight at any time: accept -> forward downstream -> wait for response ->
// return the response to the requester that issued it.
//
// Build option: NPC_ARB_RR_EN
//   defined   - round-robin on a tie, using a 1-bit "last granted" pointer
//   undefined - fixed priority, LSU wins every tie
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction, grant one valid requester
// REQ    | mem_req_valid high with latched fields, waiting for mem_req_ready
// WAIT   | request taken downstream, waiting for mem_resp_valid
module npc_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        state;
    logic              owner_lsu;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;

    logic grant_ifu;
    logic grant_lsu;
    logic ifu_accept;
    logic lsu_accept;

`ifdef NPC_ARB_RR_EN
    // 1 = LSU was granted last; reset value makes the IFU win the first tie
    logic last_lsu;

    // Round-robin: on a tie, the requester not granted last time wins
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = ~last_lsu;
            grant_ifu = last_lsu;
        end else begin
            grant_lsu = lsu_req_valid;
            grant_ifu = ifu_req_valid;
        end
    end

    // Pointer follows every accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_lsu <= 1'b1;
        end else if (ifu_accept || lsu_accept) begin
            last_lsu <= lsu_accept;
        end
    end
`else
    // Fixed priority: the LSU wins every tie
    always_comb begin
        grant_lsu = lsu_req_valid;
        grant_ifu = ifu_req_valid & ~lsu_req_valid;
    end
`endif

    assign ifu_req_ready = (state == S_IDLE) & grant_ifu;
    assign lsu_req_ready = (state == S_IDLE) & grant_lsu;
    assign ifu_accept    = ifu_req_valid & ifu_req_ready;
    assign lsu_accept    = lsu_req_valid & lsu_req_ready;

    assign mem_req_valid = (state == S_REQ);
    assign mem_req_addr  = req_addr;
    assign mem_req_wen   = req_wen;
    assign mem_req_wdata = req_wdata;
    assign mem_req_wmask = req_wmask;
    assign busy          = (state != S_IDLE);

    // Transaction sequencing, request latching and response return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            owner_lsu      <= 1'b0;
            req_addr       <= '0;
            req_wen        <= 1'b0;
            req_wdata      <= '0;
            req_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (lsu_accept) begin
                        owner_lsu <= 1'b1;
                        req_addr  <= lsu_req_addr;
                        req_wen   <= lsu_req_wen;
                        req_wdata <= lsu_req_wdata;
                        req_wmask <= lsu_req_wmask;
                        state     <= S_REQ;
                    end else if (ifu_accept) begin
                        owner_lsu <= 1'b0;
                        req_addr  <= ifu_req_addr;
                        req_wen   <= 1'b0;
                        req_wdata <= '0;
                        req_wmask <= '0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= S_IDLE;
                        if (owner_lsu) begin
                            lsu_resp_valid <= 1'b1;
                            // stores return no data
                            lsu_resp_data  <= req_wen ? '0 : mem_resp_data;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_resp_data  <= mem_resp_data;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/npc_mem_arbiter.md
# npc_mem_arbiter

Two-requester arbiter sharing the single NPC physical-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). Sits between the IFU/LSU and the pmem access block. Accepts one request at a time, forwards it downstream with a valid/ready handshake, waits for the variable-latency response, and returns it to the owning requester. Exactly one transaction is in flight.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width; wmask width is DATA_W/8

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  arbiter accepts IFU request this cycle
- ifu_req_addr  in  ADDR_W  fetch address (pc)
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_resp_data  out  DATA_W  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  arbiter accepts LSU request this cycle
- lsu_req_addr  in  ADDR_W  load/store address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DATA_W  store data
- lsu_req_wmask  in  DATA_W/8  byte-enable for store
- lsu_resp_valid  out  1  one-cycle pulse, load data valid or store done
- lsu_resp_data  out  DATA_W  load data (0 for stores)
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts
- mem_req_addr  out  ADDR_W  downstream address
- mem_req_wen  out  1  downstream write enable
- mem_req_wdata  out  DATA_W  downstream write data
- mem_req_wmask  out  DATA_W/8  downstream byte enable
- mem_resp_valid  in  1  downstream response valid
- mem_resp_data  in  DATA_W  downstream read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: select winner among valid requesters; winner's req_ready = 1 (combinational from valids and arbitration state), loser's = 0. Handshake (valid & ready) latches addr/wen/wdata/wmask and owner into registers, goes to REQ. No valid -> stay IDLE.
- IFU requests latched with wen = 0, wmask = 0, wdata = 0.
- REQ: mem_req_valid = 1 with latched fields, held stable until mem_req_ready; then -> WAIT.
- WAIT: on mem_resp_valid, capture mem_resp_data, pulse owner's resp_valid next cycle, -> IDLE. Store response: resp_data = 0.
- req_ready is 0 in REQ and WAIT.
- mem_resp_valid in IDLE or REQ: ignored, no state change.
- Requesters must accept resp_valid unconditionally; no response back-pressure.
- resp_data holds last value until next response; resp_valid is only qualifier.

## Timing
- Reset (async assert, sync release): state IDLE, all *_ready 0 only by gating (ready recomputed combinationally in IDLE), mem_req_valid 0, mem_req_* 0, *_resp_valid 0, *_resp_data 0, busy 0, arbitration pointer = LSU-last (IFU wins first tie).
- Handshake cycle T in IDLE -> mem_req_valid high from T+1.
- mem_req_ready at cycle R (in REQ) -> WAIT from R+1; mem_req_ready sampled in same cycle valid is high, so R ≥ T+1.
- mem_resp_valid at cycle W (in WAIT, W ≥ R+1) -> owner resp_valid high in W+1 only, state IDLE in W+1; new request accepted in W+1 earliest.
- Minimum round trip: accept T, mem ready T+1, mem resp T+2, resp_valid T+3, next accept T+3.
- Reset mid-transaction: in-flight request dropped, no response pulse issued; downstream must also be reset.

## Configuration
- NPC_ARB_RR_EN defined: round-robin; 1-bit pointer records last granted requester; on tie the other requester wins; pointer updated on every accept.
- Undefined: fixed priority, LSU wins every tie; pointer logic absent.
- Single-requester behaviour identical in both builds.

## Test plan
- Reset: rst_n=0 mid-WAIT -> all outputs 0 immediately, busy 0; after release IFU request to 0x80000000 accepted in first IDLE cycle.
- IFU read: ifu_req addr 0x80000000, mem ready same cycle as valid, mem resp 0x00000413_00100093 two cycles later -> ifu_resp_valid one cycle, data matches, lsu_resp_valid stays 0.
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> mem_req fields match exactly, held stable while mem_req_ready=0 for 5 cycles; lsu_resp_valid pulse, data 0.
- Simultaneous requests every cycle for 8 transactions: with NPC_ARB_RR_EN grants alternate IFU,LSU,IFU...; without, all 8 grants LSU, IFU ready never 1.
- Stray mem_resp_valid in IDLE and during REQ -> no resp_valid pulse, state unchanged.
- Back-to-back: response at W, new IFU request accepted at W+1, mem_req_valid at W+2.
